mult_share_arbiter: RTL
=======================

# mult_share_arbiter

Round-robin arbiter and sequencer that shares one 4x4 sequential multiplier between two requesters. It captures a winning requester's operands, issues a one-cycle start to the multiplier and holds its operands stable. It then waits for completion and returns the 8-bit product, tagged with the requester id. A watchdog aborts any operation the multiplier never completes.

## Interface
Parameters:
- TIMEOUT, 15, max WAIT cycles before abort (1..255).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous and active-high.
- req0, req1  in  1 each  requester i wants a multiply; held high until its res_valid.
- a0, b0, a1, b1  in  4 each  operands of requester i, valid while req i is high.
- gnt0, gnt1  out  1 each  requester i owns the multiplier; high from START through RESP.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  one-cycle result strobe.
- res_id  out  1  requester the result belongs to.
- res  out  8  product; 0 on error.
- err  out  1  high with res_valid when the operation timed out.
- mul_start  out  1  one-cycle start to the multiplier.
- mul_a, mul_b  out  4 each  operands to the multiplier, held stable START..RESP.
- mul_done  in  1  multiplier completion (level or pulse).
- mul_out  in  8  multiplier product, valid while mul_done is high.

## Operation
- States: IDLE, START, WAIT, RESP. Encoded in a 2-bit state register.
- IDLE:
  - If no request, stay.
  - If exactly one of req0/req1 is high, grant it.
  - If both are high, grant the requester that is not `last`. `last` is a 1-bit pointer, reset to 1, so req0 wins the first tie.
  - On grant, register the id into `cur` and register a_cur/b_cur into mul_a/mul_b, then go to START.
- START:
  - mul_start=1 and gnt[cur]=1.
  - Clear the wait counter `wcnt` (8 bits).
  - Go to WAIT.
- WAIT:
  - wcnt increments every cycle, saturating at 255.
  - mul_done is ignored while wcnt==0, which rejects a stale done from the previous operation.
  - If wcnt>=1 and mul_done=1: register mul_out into res, set err=0, go to RESP.
  - Otherwise, if wcnt==TIMEOUT: set res=0, err=1, go to RESP.
  - mul_done takes priority over the timeout in the same cycle.
- RESP:
  - res_valid=1, res_id=cur, gnt[cur]=1.
  - Set last<=cur, then go to IDLE.
- Requester contract: deassert req on the edge that samples res_valid=1. A req still high in IDLE is a new request.
- Operands are captured at grant, so the requester may change a/b after gnt.
- A req arriving mid-operation waits; it is not lost while held high.
- mul_a/mul_b hold their last values in IDLE.
- res/res_id/err hold their last values after RESP; they are meaningful only when res_valid=1.
- Width rules:
  - The 4x4 unsigned product fits in 8 bits, and res is passed through unmodified.
  - The watchdog compares against an 8-bit wcnt, and TIMEOUT must be at most 255.

## Timing
- Reset: state=IDLE, last=1, cur=0, wcnt=0. All outputs are 0: gnt0, gnt1, busy, res_valid, res_id, res, err, mul_start, mul_a, mul_b.
- rst has priority over every state, including mid-WAIT. The abandoned operation produces no res_valid.
- Latency, req sampled in IDLE at edge 0:
  - START during cycle 1; WAIT from cycle 2.
  - If mul_done is first accepted in WAIT cycle k (k>=2 relative to the start of WAIT, counting from 1), RESP occurs in the following cycle.
  - Total = 1 (START) + k (WAIT) + 1 (RESP) cycles.
- Earliest return to IDLE: the cycle after RESP. Back-to-back requests therefore have a minimum 1-cycle IDLE gap.
- Timeout: RESP follows the WAIT cycle where wcnt==TIMEOUT. With TIMEOUT=15, the first RESP cycle is 17 cycles after the START cycle.
- mul_start is high in exactly one cycle per operation. It is never asserted in WAIT, RESP or IDLE.

## Test plan
- Single request, real multiplier: req0 with a0=14, b0=11 → gnt0 high, one mul_start, then res_valid with res_id=0, res=154, err=0. req1 stays ungranted.
- Tie after reset: req0 (6×12) and req1 (13×13) asserted in the same cycle → first result res_id=0, res=72, then res_id=1, res=169. There is exactly one IDLE cycle between the two operations.
- Fairness: both requesters hold req continuously for 6 operations → res_id sequence is 0,1,0,1,0,1, and no gnt0 and gnt1 are ever high together.
- Watchdog: stub multiplier with mul_done=0, TIMEOUT=15 → res_valid with err=1 and res=0, 17 cycles after START. The arbiter then accepts the next request normally.
- Stale done: stub holds mul_done=1 with mul_out=0xAA into START and the first WAIT cycle, then presents the correct product → the arbiter ignores the stale 0xAA and returns the correct product.
- Reset mid-WAIT: assert rst for 1 cycle while busy → next cycle all outputs are 0, no res_valid. A following req1 (3×5) yields res_id=1, res=15.

Source files
------------

// File: rtl/mult_share_arbiter_if.sv
// Handshake bundle between two requesters, the shared 4x4 multiplier
// and the arbiter. Ports: req/a/b per requester, gnt/res_* back to the
// requesters, mul_start/mul_a/mul_b out to the multiplier and
// mul_done/mul_out back from it.
// Modports: slave = arbiter side, master = requesters plus multiplier.
interface mult_share_arbiter_if;
    logic       req0;
    logic       req1;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic       res_valid;
    logic       res_id;
    logic [7:0] res;
    logic       err;
    logic       mul_start;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic       mul_done;
    logic [7:0] mul_out;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, mul_done, mul_out,
        output gnt0, gnt1, busy, res_valid, res_id, res, err,
        output mul_start, mul_a, mul_b
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, mul_done, mul_out,
        input  gnt0, gnt1, busy, res_valid, res_id, res, err,
        input  mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential 4x4 multiplier between two
// requesters, with a watchdog that aborts an operation never completed.
// Ports: clk, rst (sync, active-high), bus (slave modport: requests,
// operands, grants, tagged result, multiplier start/operands/done).
module mult_share_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_share_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] TO_W = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic       cur_q, cur_d;
    logic       res_id_q, res_id_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic [3:0] mul_a_q, mul_a_d;
    logic [3:0] mul_b_q, mul_b_d;
    logic [7:0] res_q, res_d;
    logic       err_q, err_d;
    logic       win;

    // On a tie the requester that was not served last wins.
    assign win = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            cur_q    <= 1'b0;
            res_id_q <= 1'b0;
            wcnt_q   <= 8'd0;
            mul_a_q  <= 4'd0;
            mul_b_q  <= 4'd0;
            res_q    <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cur_q    <= cur_d;
            res_id_q <= res_id_d;
            wcnt_q   <= wcnt_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cur_d    = cur_q;
        res_id_d = res_id_q;
        wcnt_d   = wcnt_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        res_d    = res_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    cur_d   = win;
                    mul_a_d = win ? bus.a1 : bus.a0;
                    mul_b_d = win ? bus.b1 : bus.b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                wcnt_d  = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q != 8'hFF) begin
                    wcnt_d = wcnt_q + 8'd1;
                end
                // wcnt==0 masks a done left over from the previous op.
                if (wcnt_q != 8'd0 && bus.mul_done) begin
                    res_d    = bus.mul_out;
                    err_d    = 1'b0;
                    res_id_d = cur_q;
                    state_d  = S_RESP;
                end else if (wcnt_q == TO_W) begin
                    res_d    = 8'd0;
                    err_d    = 1'b1;
                    res_id_d = cur_q;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                last_d  = cur_q;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.gnt0      = bus.busy && !cur_q;
    assign bus.gnt1      = bus.busy && cur_q;
    assign bus.mul_start = (state_q == S_START);
    assign bus.res_valid = (state_q == S_RESP);
    assign bus.res_id    = res_id_q;
    assign bus.res       = res_q;
    assign bus.err       = err_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;

endmodule
